// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-stream sources share one TX stream.
// A grant is held for a whole frame; the output is a one-entry register slice.

module eth_tx_arb_lane #(
    parameter int PW  = 2,
    parameter int IDX = 0
) (
    input  logic          pass,
    input  logic [PW-1:0] grant_id,
    input  logic          slot_free,
    input  logic          valid,
    output logic          ready,
    output logic          xfer
);
    assign ready = pass && slot_free && (grant_id == PW'(IDX));
    assign xfer  = ready && valid;
endmodule

module eth_tx_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  stream_in_DATA,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  stream_in_KEEP,
    input  logic [NUM_PORTS-1:0]             stream_in_LAST,
    input  logic [NUM_PORTS-1:0]             stream_in_VALID,
    output logic [NUM_PORTS-1:0]             stream_in_READY,
    output logic [DATA_WIDTH-1:0]            stream_out_DATA,
    output logic [KEEP_WIDTH-1:0]            stream_out_KEEP,
    output logic                             stream_out_LAST,
    output logic                             stream_out_VALID,
    input  logic                             stream_out_READY,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
    output logic                             busy,
    output logic [31:0]                      frame_count
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    logic [0:0]                            state;
    logic [PW-1:0]                         ptr;
    logic                                  out_valid_q;
    beat_t                                 out_q;
    beat_t                                 in_beat;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  in_data;
    logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0]  in_keep;
    logic [NUM_PORTS-1:0]                  xfer;
    logic                                  pass;
    logic                                  slot_free;
    logic                                  load;
    logic                                  found;
    logic [PW-1:0]                         win;
    logic [PW:0]                           idx;
    logic [PW-1:0]                         grant_inc;

    assign in_data   = stream_in_DATA;
    assign in_keep   = stream_in_KEEP;
    assign pass      = (state == PASS);
    assign slot_free = !out_valid_q || stream_out_READY;
    assign load      = |xfer;
    assign in_beat   = '{data: in_data[grant_id], keep: in_keep[grant_id],
                         last: stream_in_LAST[grant_id]};

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
            eth_tx_arb_lane #(.PW(PW), .IDX(p)) u_lane (
                .pass      (pass),
                .grant_id  (grant_id),
                .slot_free (slot_free),
                .valid     (stream_in_VALID[p]),
                .ready     (stream_in_READY[p]),
                .xfer      (xfer[p])
            );
        end
    endgenerate

    // First requester at or after ptr; the explicit wrap keeps non-power-of-two counts exact.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_PORTS))
                idx = idx - (PW+1)'(NUM_PORTS);
            if (!found && stream_in_VALID[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign grant_inc = (grant_id == PW'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_id <= win;
                    state    <= PASS;
                end
                PASS: if (load && in_beat.last) begin
                    state <= IDLE;
                    ptr   <= grant_inc;
                end
                default: state <= IDLE;
            endcase

            // Load wins over drain so a back-to-back beat keeps VALID high.
            if (load) begin
                out_valid_q <= 1'b1;
                out_q       <= in_beat;
            end else if (stream_out_READY) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && stream_out_READY && out_q.last)
                frame_count <= frame_count + 32'd1;
        end
    end

    assign stream_out_DATA  = out_q.data;
    assign stream_out_KEEP  = out_q.keep;
    assign stream_out_LAST  = out_q.last;
    assign stream_out_VALID = out_valid_q;
    assign busy             = pass;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: per-port source queues, output scoreboard,
// grant-order log and hand-computed expectations for each scenario.

module tb_eth_tx_arbiter;
    localparam int NP = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*64-1:0]  in_data;
    logic [NP*8-1:0]   in_keep;
    logic [NP-1:0]     in_last, in_valid, in_ready;
    logic [63:0]       out_data;
    logic [7:0]        out_keep;
    logic              out_last, out_valid, out_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic [31:0]       frame_count;

    eth_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .stream_in_DATA   (in_data),
        .stream_in_KEEP   (in_keep),
        .stream_in_LAST   (in_last),
        .stream_in_VALID  (in_valid),
        .stream_in_READY  (in_ready),
        .stream_out_DATA  (out_data),
        .stream_out_KEEP  (out_keep),
        .stream_out_LAST  (out_last),
        .stream_out_VALID (out_valid),
        .stream_out_READY (out_ready),
        .grant_id         (grant_id),
        .busy             (busy),
        .frame_count      (frame_count)
    );

    always #5 clk = ~clk;

    beat_t       src_q [NP][$];
    beat_t       exp_q [$];
    beat_t       obs_q [$];
    int          grant_q [$];
    int          sent [NP];
    int          stall_cnt [NP];
    int          gap_after [NP];
    int          gap_len [NP];
    int          n_cmp = 0, n_bad = 0;
    int          stab_err = 0, stall_seen = 0, onehot_err = 0;
    bit          bp_mode = 0, tog = 0, stall_prev = 0, busy_prev = 0;
    beat_t       held;
    logic [NP-1:0] fire;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int p, input int i, input int n, input int tag);
        beat_t b;
        b.data = {16'(tag), 8'(p), 8'(i), 32'hC0DE_0000 + 32'(i)};
        b.keep = 8'hFF;
        b.last = (i == n - 1);
        return b;
    endfunction

    // Queue a frame on port p and, when it is expected next in the output order, on the scoreboard.
    task automatic push_frame(input int p, input int n, input int tag, input bit to_exp);
        for (int i = 0; i < n; i++) begin
            src_q[p].push_back(mk_beat(p, i, n, tag));
            if (to_exp) exp_q.push_back(mk_beat(p, i, n, tag));
        end
    endtask

    task automatic exp_frame(input int p, input int n, input int tag);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(p, i, n, tag));
    endtask

    function automatic bit src_empty();
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int gq(input int i);
        return (grant_q.size() > i) ? grant_q[i] : -1;
    endfunction

    task automatic wait_done(input string tag, input int max_cyc);
        bit done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge clk); #1;
            done = src_empty() && !out_valid && !busy;
        end
        if (!done) chk({tag, "_timeout"}, 80'd0, 80'd1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_nbeats"}, 80'(obs_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 80'(obs_q[i]), 80'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_sent(input int p, input int n);
        for (int c = 0; c < 200 && sent[p] < n; c++) begin
            @(posedge clk); #1;
        end
        chk($sformatf("sent_p%0d", p), 80'(sent[p] >= n), 80'd1);
    endtask

    // Sources and monitor: drive at negedge, sample just before posedge, pop on the edge.
    initial begin
        in_valid  = '0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (stall_cnt[p] > 0) begin
                    in_valid[p] = 1'b0;
                    stall_cnt[p]--;
                end else if (src_q[p].size() > 0) begin
                    in_valid[p]        = 1'b1;
                    in_data[p*64 +: 64] = src_q[p][0].data;
                    in_keep[p*8 +: 8]   = src_q[p][0].keep;
                    in_last[p]         = src_q[p][0].last;
                end else begin
                    in_valid[p] = 1'b0;
                end
            end
            tog       = !tog;
            out_ready = bp_mode ? tog : 1'b1;
            #4;
            fire = in_valid & in_ready;
            if (out_valid && out_ready) obs_q.push_back(beat_t'({out_data, out_keep, out_last}));
            if (stall_prev && beat_t'({out_data, out_keep, out_last}) != held) stab_err++;
            stall_prev = out_valid && !out_ready && !rst;
            if (stall_prev) stall_seen++;
            held = beat_t'({out_data, out_keep, out_last});
            if ($countones(in_ready) > 1) onehot_err++;
            if (busy && !busy_prev) grant_q.push_back(int'(grant_id));
            busy_prev = busy;
            @(posedge clk);
            for (int p = 0; p < NP; p++) begin
                if (fire[p] && !rst && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                    sent[p]++;
                    if (sent[p] == gap_after[p]) stall_cnt[p] = gap_len[p];
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beat_t      sf [5];
        logic [8:0] pat;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 80'(out_valid), 80'd0);
        chk("rst_data", 80'(out_data), 80'd0);
        chk("rst_keep", 80'(out_keep), 80'd0);
        chk("rst_last", 80'(out_last), 80'd0);
        chk("rst_ready", 80'(in_ready), 80'd0);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_fc", 80'(frame_count), 80'd0);
        chk("rst_grant", 80'(grant_id), 80'd0);

        // Single frame on port 0 with the reference vectors
        rst   = 1'b0;
        sf[0] = '{64'h0011_2233_4455_6677, 8'hFF, 1'b0};
        sf[1] = '{64'h8899_AABB_CCDD_EEFF, 8'hFF, 1'b0};
        sf[2] = '{64'h0800_4500_0034_1234, 8'hFF, 1'b0};
        sf[3] = '{64'h0100_0001_0003_0000, 8'hFF, 1'b0};
        sf[4] = '{64'h5073_9302_0000_0000, 8'h0F, 1'b1};
        grant_q.delete();
        for (int i = 0; i < 5; i++) begin
            src_q[0].push_back(sf[i]);
            exp_q.push_back(sf[i]);
        end
        @(posedge clk); #1;
        chk("lat_busy", 80'(busy), 80'd1);
        chk("lat_noout", 80'(out_valid), 80'd0);
        @(posedge clk); #1;
        chk("lat_first", 80'({out_valid, out_data}), 80'({1'b1, sf[0].data}));
        repeat (4) @(posedge clk);
        #1;
        chk("nobubble_last", 80'({out_valid, out_last, out_keep, out_data}),
            80'({1'b1, 1'b1, 8'h0F, 64'h5073_9302_0000_0000}));
        wait_done("single", 100);
        cmp_stream("single");
        chk("single_fc", 80'(frame_count), 80'd1);
        chk("single_ptr", 80'(dut.ptr), 80'd1);

        // Fairness: port 1 always requesting, ptr starts at 1
        grant_q.delete();
        push_frame(1, 2, 10, 1'b0);
        push_frame(1, 2, 11, 1'b0);
        push_frame(1, 2, 12, 1'b0);
        push_frame(0, 3, 20, 1'b0);
        push_frame(3, 3, 30, 1'b0);
        exp_frame(1, 2, 10);
        exp_frame(3, 3, 30);
        exp_frame(0, 3, 20);
        exp_frame(1, 2, 11);
        exp_frame(1, 2, 12);
        wait_done("fair", 200);
        cmp_stream("fair");
        chk("fair_g0", 80'(gq(0)), 80'd1);
        chk("fair_g1", 80'(gq(1)), 80'd3);
        chk("fair_g2", 80'(gq(2)), 80'd0);
        chk("fair_g3", 80'(gq(3)), 80'd1);
        chk("fair_fc", 80'(frame_count), 80'd6);

        // Contention from ptr=0: ports 0 and 2 together
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        grant_q.delete();
        push_frame(0, 4, 2, 1'b1);
        push_frame(2, 4, 3, 1'b1);
        for (int c = 0; c < 50 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            pat = {pat[7:0], out_valid};
            @(posedge clk); #1;
        end
        chk("cont_gap", 80'(pat), 80'(9'b111101111));
        wait_done("cont", 100);
        cmp_stream("cont");
        chk("cont_g0", 80'(gq(0)), 80'd0);
        chk("cont_g1", 80'(gq(1)), 80'd2);
        chk("cont_ptr", 80'(dut.ptr), 80'd3);
        chk("cont_fc", 80'(frame_count), 80'd2);

        // Backpressure: 8-beat frame with stream_out_READY toggling
        grant_q.delete();
        stab_err   = 0;
        stall_seen = 0;
        bp_mode    = 1'b1;
        push_frame(3, 8, 40, 1'b1);
        wait_done("bp", 200);
        bp_mode = 1'b0;
        cmp_stream("bp");
        chk("bp_stable", 80'(stab_err), 80'd0);
        chk("bp_stalled", 80'(stall_seen != 0), 80'd1);
        chk("bp_ptr", 80'(dut.ptr), 80'd0);

        // Source gap: port 0 pauses 5 cycles after 2 beats while port 1 requests
        grant_q.delete();
        sent[0]      = 0;
        gap_after[0] = 2;
        gap_len[0]   = 5;
        push_frame(0, 4, 50, 1'b1);
        push_frame(1, 2, 51, 1'b1);
        wait_sent(0, 2);
        repeat (4) begin
            @(posedge clk); #1;
            chk("gap_busy", 80'(busy), 80'd1);
            chk("gap_grant", 80'(grant_id), 80'd0);
            chk("gap_rdy1", 80'(in_ready[1]), 80'd0);
        end
        wait_done("gap", 200);
        gap_after[0] = 0;
        cmp_stream("gap");
        chk("gap_g0", 80'(gq(0)), 80'd0);
        chk("gap_g1", 80'(gq(1)), 80'd1);
        chk("gap_fc", 80'(frame_count), 80'd5);

        // Reset mid-frame after beat 2 of a 6-beat frame
        sent[2] = 0;
        push_frame(2, 6, 60, 1'b0);
        wait_sent(2, 2);
        rst = 1'b1;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        @(posedge clk); #1;
        chk("mid_valid", 80'(out_valid), 80'd0);
        chk("mid_beat", 80'({out_data, out_keep, out_last}), 80'd0);
        chk("mid_ready", 80'(in_ready), 80'd0);
        chk("mid_busy", 80'(busy), 80'd0);
        chk("mid_fc", 80'(frame_count), 80'd0);
        chk("mid_grant", 80'(grant_id), 80'd0);
        chk("mid_ptr", 80'(dut.ptr), 80'd0);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        grant_q.delete();
        push_frame(1, 3, 61, 1'b1);
        wait_done("post", 100);
        cmp_stream("post");
        chk("post_fc", 80'(frame_count), 80'd1);
        chk("post_g0", 80'(gq(0)), 80'd1);

        chk("onehot_ready", 80'(onehot_err), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
